// File: rtl/instruction_fetch.sv
// Fetch stage: PC register drives instruction memory; {pc, instr} pairs are buffered for decode.
// Latency: one cycle from fetch edge to out_valid; redirect flushes and restarts; out_ready=0 stalls fetch at DEPTH.

module fetch_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 2,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdat,
    output logic [W-1:0]  rdat,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdat;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdat = mem[rd_ptr];
endmodule

module instruction_fetch #(
    parameter int          N        = 8,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic [N-1:0] imem_addr,
    input  logic [31:0]  imem_rd,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_instr,
    output logic [N-1:0] out_pc
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [N-1:0] pc;
        logic [31:0]  instr;
    } entry_t;

    logic [N-1:0]  fetch_pc;
    logic [N-1:0]  redirect_base;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    entry_t        wr_entry;
    entry_t        head;

    assign redirect_base = redirect_pc & ~N'(3);
    assign out_valid     = (count != '0) & !redirect_valid;
    assign pop           = out_valid & out_ready;
    // A pop frees a slot this edge, so a full buffer keeps streaming
    assign push          = !redirect_valid & ((count < CW'(DEPTH)) | pop);
    assign wr_entry      = '{pc: fetch_pc, instr: imem_rd};
    assign imem_addr     = fetch_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_base;
        end else if (push) begin
            fetch_pc <= fetch_pc + N'(4);
        end
    end

    fetch_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .wdat  (wr_entry),
        .rdat  (head),
        .count (count)
    );

    assign out_instr = out_valid ? head.instr : 32'h0000_0013;
    assign out_pc    = out_valid ? head.pc : '0;
endmodule
